decode_issue_ctrl: RTL

- Decode/issue stage controller for the MIPS-style core; sits between instruction fetch and the execute stage.
- Splits each 32-bit instruction into its source and destination register fields.
- Tracks in-flight register writes in a 32-entry scoreboard and stalls read-after-write hazards.
- Passes instructions downstream through valid/ready handshakes, and kills in-stage work on a branch/jump redirect flush.

---
 rtl/decode_issue_ctrl_if.sv | 34 +++
 rtl/decode_issue_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl_if.sv
// Purpose: fetch->decode->execute handshake bundle plus writeback/flush/stats for decode_issue_ctrl.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the fetch side, out_valid/out_ready on the execute side.
// Ports (slave = decode stage): in_* from fetch, out_* to execute, wb_* from writeback,
// flush from redirect logic, stall_cnt statistics output.
interface decode_issue_ctrl_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      out_dst;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic            flush;
  logic [31:0]     stall_cnt;

  // Driver side: fetch, execute-ready, writeback and redirect sources.
  modport master (
    output in_valid, in_inst, in_pc, out_ready, wb_en, wb_addr, flush,
    input  in_ready, out_valid, out_inst, out_pc, out_dst, stall_cnt
  );

  // Decode/issue stage side.
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready, wb_en, wb_addr, flush,
    output in_ready, out_valid, out_inst, out_pc, out_dst, stall_cnt
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Purpose: decode/issue controller; decodes register fields, scoreboards in-flight writes, stalls RAW hazards.
// Latency: one cycle from acceptance into the hold register to out_valid (no hazard, no backpressure).
// Backpressure: out_valid && !out_ready freezes the output register; a stalled hold register drops in_ready.
// Ports: clk/rstn (async active-low); bus (slave modport) carries fetch in_*, execute out_*,
// writeback wb_*, flush, and the saturating hazard-stall counter stall_cnt.
module decode_issue_ctrl #(
  parameter int PC_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  decode_issue_ctrl_if.slave   bus
);

  // Hold register (H)
  logic            r_h_vld;
  logic [31:0]     r_h_inst;
  logic [PC_W-1:0] r_h_pc;
  // Output register (O)
  logic            r_o_vld;
  logic [31:0]     r_o_inst;
  logic [PC_W-1:0] r_o_pc;
  logic [4:0]      r_o_dst;
  // Scoreboard of pending register writes; bit 0 never set.
  logic [31:0]     r_sb;
  logic [31:0]     r_stall_cnt;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_dst;
  logic        w_use_rs;
  logic        w_use_rt;
  logic        w_rs_haz;
  logic        w_rt_haz;
  logic        w_hazard;
  logic        w_issue;
  logic        w_in_rdy;
  logic        w_accept;
  logic        w_fire;
  logic [31:0] w_sb_nxt;

  assign w_op    = r_h_inst[31:26];
  assign w_rs    = r_h_inst[25:21];
  assign w_rt    = r_h_inst[20:16];
  assign w_rd    = r_h_inst[15:11];
  assign w_funct = r_h_inst[5:0];

  // Decode of the held instruction: which fields are read and which is written.
  always_comb begin
    w_dst    = 5'd0;
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    case (w_op) inside
      6'h00: begin
        // jr reads rs only and writes nothing
        w_use_rs = 1'b1;
        if (w_funct == 6'h08) begin
          w_dst = 5'd0;
        end else begin
          w_dst    = w_rd;
          w_use_rt = 1'b1;
        end
      end
      6'h03: w_dst = 5'd31;
      6'h04, 6'h05: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      [6'h08:6'h0E]: begin
        w_dst    = w_rt;
        w_use_rs = 1'b1;
      end
      6'h0F: w_dst = w_rt;
      [6'h20:6'h25]: begin
        w_dst    = w_rt;
        w_use_rs = 1'b1;
      end
      [6'h28:6'h2B]: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // A source conflicts with a pending scoreboard write or with the instruction
  // sitting in O, whose scoreboard bit is only set once execute accepts it.
  assign w_rs_haz = w_use_rs && (w_rs != 5'd0) &&
                    (r_sb[w_rs] || (r_o_vld && (r_o_dst == w_rs)));
  assign w_rt_haz = w_use_rt && (w_rt != 5'd0) &&
                    (r_sb[w_rt] || (r_o_vld && (r_o_dst == w_rt)));
  assign w_hazard = w_rs_haz || w_rt_haz;

  assign w_fire   = r_o_vld && bus.out_ready;
  assign w_issue  = r_h_vld && !w_hazard && (!r_o_vld || bus.out_ready) && !bus.flush;
  assign w_in_rdy = !r_h_vld || w_issue;
  assign w_accept = bus.in_valid && w_in_rdy && !bus.flush;

  // Set wins over a same-cycle writeback clear of the same register.
  always_comb begin
    w_sb_nxt = r_sb;
    if (bus.wb_en) w_sb_nxt[bus.wb_addr] = 1'b0;
    if (w_fire)    w_sb_nxt[r_o_dst]     = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_h_vld     <= 1'b0;
      r_h_inst    <= '0;
      r_h_pc      <= '0;
      r_o_vld     <= 1'b0;
      r_o_inst    <= '0;
      r_o_pc      <= '0;
      r_o_dst     <= '0;
      r_sb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_sb <= w_sb_nxt;

      if (r_h_vld && w_hazard && !bus.flush && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;

      if (bus.flush) begin
        r_h_vld <= 1'b0;
      end else if (w_accept) begin
        r_h_vld  <= 1'b1;
        r_h_inst <= bus.in_inst;
        r_h_pc   <= bus.in_pc;
      end else if (w_issue) begin
        r_h_vld <= 1'b0;
      end

      // Issue is already blocked during flush, so a flushed O simply empties.
      if (w_issue) begin
        r_o_vld  <= 1'b1;
        r_o_inst <= r_h_inst;
        r_o_pc   <= r_h_pc;
        r_o_dst  <= w_dst;
      end else if (w_fire || bus.flush) begin
        r_o_vld <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_rdy;
  assign bus.out_valid = r_o_vld;
  assign bus.out_inst  = r_o_inst;
  assign bus.out_pc    = r_o_pc;
  assign bus.out_dst   = r_o_dst;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
